vga_out_pipe: RTL and testbench
===============================

Name: vga_out_pipe

Overview:
- Parametrised successor to the pong top-level RGB buffer: registered video output stage between vga_sync/graphics generators and board pins.
- Delays hsync/vsync/video_on and RGB through one common PIXEL_LAT-stage pipeline advanced by p_tick, so sync and colour stay aligned at any depth.
- Adds generic colour width, blanking enforcement, per-frame counter, and a frame-synchronous source-mode switch (graphics / colour bars / solid / black).

Parameters:
- RGB_W, 3, total colour bits; multiple of 3; channel width C = RGB_W/3, packed {R,G,B} with R in the MSBs.
- PIXEL_LAT, 2, pipeline depth in p_tick stages, 1..8.
- FCNT_W, 8, width of the frame counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- p_tick  in  1  pixel enable from vga_sync; the pipeline advances only when p_tick=1
- video_on_in  in  1  active-area flag, aligned with pixel_x/pixel_y
- hsync_in  in  1  horizontal sync from vga_sync
- vsync_in  in  1  vertical sync from vga_sync
- pixel_x  in  10  current column
- pixel_y  in  10  current row
- graph_rgb  in  RGB_W  colour from the graphics generator
- bg_rgb  in  RGB_W  colour used in solid mode
- mode_req  in  2  requested mode: 0 graph, 1 bars, 2 solid, 3 black
- mode_load  in  1  single-cycle strobe that captures mode_req as the pending mode
- hsync  out  1  delayed hsync
- vsync  out  1  delayed vsync
- video_on  out  1  delayed video_on_in
- rgb  out  RGB_W  registered colour
- mode_active  out  2  mode currently in effect
- mode_pending  out  1  a loaded mode is waiting for the frame boundary
- frame_cnt  out  FCNT_W  number of frames started since reset

Behaviour:
- Reset (rst=1 at a clk edge; overrides p_tick and mode_load):
  - All pipeline stages clear, so hsync=vsync=video_on=0 and rgb=0.
  - mode_active=0, mode_pending=0, pending register=0, frame_cnt=0.
- Pipeline:
  - Stage 0 loads {hsync_in, vsync_in, video_on_in, colour_sel} on a clk edge with p_tick=1. Stage k loads stage k-1 on the same edge.
  - Outputs are driven directly from stage PIXEL_LAT-1.
  - Latency: an input sampled at p_tick edge n appears on the outputs after edge n+PIXEL_LAT-1. With PIXEL_LAT=1 this is the legacy one-register buffer.
  - With p_tick=0 every stage holds.
- colour_sel, combinational, from the inputs and mode_active:
  - video_on_in=0: all zeros, in every mode.
  - Mode 0: graph_rgb.
  - Mode 1: b = pixel_x[8:6]; R = {C{b[2]}}, G = {C{b[1]}}, B = {C{b[0]}}. This gives 64-pixel bars cycling black→white.
  - Mode 2: bg_rgb.
  - Mode 3: all zeros.
- Frame boundary: a clk edge with p_tick=1 and pixel_x=0 and pixel_y=0 at the input. On that edge:
  - frame_cnt increments, wrapping from 2^FCNT_W-1 to 0.
  - If mode_pending=1: mode_active takes the pending value and mode_pending clears.
  - The boundary pixel itself is coloured with the old mode; the new mode applies from the next p_tick pixel.
- mode_load: on any edge, pending register <= mode_req and mode_pending <= 1.
  - A later mode_load before the boundary overwrites the pending value (last write wins).
  - mode_load on the boundary edge: the previous pending value, if any, is applied; the new value becomes pending (mode_pending stays 1). mode_load is honoured even when p_tick=0.
  - Loading the same value as mode_active still waits for the boundary.
- No combinational path from any input to any output.

Test Plan:
- PIXEL_LAT=2, mode 0, graph_rgb=3'b101, video_on_in=1, hsync_in pulsed low for one p_tick → rgb=101 and hsync low both appear exactly 2 p_ticks later, in the same cycle.
- PIXEL_LAT=4, p_tick every 4th clk, video_on_in toggled at pixel 640 → rgb becomes 0 in the same output cycle that video_on falls, 4 ticks after the input.
- mode_load with mode_req=1 at row 100 → mode_active stays 0 and mode_pending=1 until (0,0). After the boundary, pixel_x=64 gives rgb=001 and pixel_x=448 gives rgb=111.
- mode_load of 2 then 3 within one frame, bg_rgb=010 → only 3 is applied at the boundary; mode 2 never appears; rgb=000 over the whole next frame.
- FCNT_W=2, run 5 frames → frame_cnt sequence 1,2,3,0,1. mode_load coincident with the boundary → pending value is applied and the new value stays pending.
- Assert rst mid-line with mode 1 active and a load pending → next cycle: rgb=0, hsync=vsync=video_on=0, mode_active=0, mode_pending=0, frame_cnt=0.

Source files
------------

// File: rtl/vga_out_pipe_if.sv
// Signal bundle between the video sources (vga_sync, graphics) and the registered output stage.
// The master side drives pixel/sync/colour/mode requests; the slave side returns pin-level video.
interface vga_out_pipe_if #(
  parameter int unsigned RGB_W  = 3,
  parameter int unsigned FCNT_W = 8
) ();
  logic              p_tick;
  logic              video_on_in;
  logic              hsync_in;
  logic              vsync_in;
  logic [9:0]        pixel_x;
  logic [9:0]        pixel_y;
  logic [RGB_W-1:0]  graph_rgb;
  logic [RGB_W-1:0]  bg_rgb;
  logic [1:0]        mode_req;
  logic              mode_load;

  logic              hsync;
  logic              vsync;
  logic              video_on;
  logic [RGB_W-1:0]  rgb;
  logic [1:0]        mode_active;
  logic              mode_pending;
  logic [FCNT_W-1:0] frame_cnt;

  modport master (
    output p_tick, video_on_in, hsync_in, vsync_in, pixel_x, pixel_y,
    output graph_rgb, bg_rgb, mode_req, mode_load,
    input  hsync, vsync, video_on, rgb, mode_active, mode_pending, frame_cnt
  );

  modport slave (
    input  p_tick, video_on_in, hsync_in, vsync_in, pixel_x, pixel_y,
    input  graph_rgb, bg_rgb, mode_req, mode_load,
    output hsync, vsync, video_on, rgb, mode_active, mode_pending, frame_cnt
  );
endinterface

// File: rtl/vga_out_pipe.sv
// Registered VGA output stage: sync, blanking and colour travel through one p_tick-advanced
// pipeline so they stay aligned; source mode switches only at the frame origin.
module vga_out_pipe #(
  parameter int unsigned RGB_W     = 3,
  parameter int unsigned PIXEL_LAT = 2,
  parameter int unsigned FCNT_W    = 8
) (
  input  logic           clk,
  input  logic           rst,
  vga_out_pipe_if.slave  bus
);
  localparam int unsigned C = RGB_W / 3;

  if ((RGB_W % 3) != 0 || RGB_W == 0 || PIXEL_LAT < 1 || PIXEL_LAT > 8) begin : g_bad_param
    $error("vga_out_pipe: illegal RGB_W or PIXEL_LAT");
  end

  logic [PIXEL_LAT-1:0] hs_q;
  logic [PIXEL_LAT-1:0] vs_q;
  logic [PIXEL_LAT-1:0] von_q;
  logic [RGB_W-1:0]     rgb_q [PIXEL_LAT];

  logic [1:0]        mode_active_q, mode_active_d;
  logic [1:0]        pend_q, pend_d;
  logic              pend_v_q, pend_v_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic              frame_bnd;
  logic [2:0]        bar;
  logic [RGB_W-1:0]  colour_sel;

  assign frame_bnd = bus.p_tick && (bus.pixel_x == 10'd0) && (bus.pixel_y == 10'd0);

  // Blanking wins over every mode, so nothing leaks outside the active area.
  always_comb begin
    bar        = bus.pixel_x[8:6];
    colour_sel = '0;
    if (bus.video_on_in) begin
      case (mode_active_q)
        2'd0:    colour_sel = bus.graph_rgb;
        2'd1:    colour_sel = {{C{bar[2]}}, {C{bar[1]}}, {C{bar[0]}}};
        2'd2:    colour_sel = bus.bg_rgb;
        default: colour_sel = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q  <= '0;
      vs_q  <= '0;
      von_q <= '0;
      for (int unsigned k = 0; k < PIXEL_LAT; k++) begin
        rgb_q[k] <= '0;
      end
    end else if (bus.p_tick) begin
      hs_q[0]  <= bus.hsync_in;
      vs_q[0]  <= bus.vsync_in;
      von_q[0] <= bus.video_on_in;
      rgb_q[0] <= colour_sel;
      for (int unsigned k = 1; k < PIXEL_LAT; k++) begin
        hs_q[k]  <= hs_q[k-1];
        vs_q[k]  <= vs_q[k-1];
        von_q[k] <= von_q[k-1];
        rgb_q[k] <= rgb_q[k-1];
      end
    end
  end

  // A load on the boundary edge applies the older pending value and queues the new one.
  always_comb begin
    mode_active_d = mode_active_q;
    pend_d        = pend_q;
    pend_v_d      = pend_v_q;
    frame_cnt_d   = frame_cnt_q;
    if (frame_bnd) begin
      frame_cnt_d = frame_cnt_q + FCNT_W'(1);
      if (pend_v_q) begin
        mode_active_d = pend_q;
        pend_v_d      = 1'b0;
      end
    end
    if (bus.mode_load) begin
      pend_d   = bus.mode_req;
      pend_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_active_q <= 2'd0;
      pend_q        <= 2'd0;
      pend_v_q      <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      mode_active_q <= mode_active_d;
      pend_q        <= pend_d;
      pend_v_q      <= pend_v_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign bus.hsync        = hs_q[PIXEL_LAT-1];
  assign bus.vsync        = vs_q[PIXEL_LAT-1];
  assign bus.video_on     = von_q[PIXEL_LAT-1];
  assign bus.rgb          = rgb_q[PIXEL_LAT-1];
  assign bus.mode_active  = mode_active_q;
  assign bus.mode_pending = pend_v_q;
  assign bus.frame_cnt    = frame_cnt_q;
endmodule

// File: tb/tb_vga_out_pipe.sv
// Scoreboard bench: two instances (latency 2 / 2-bit frame counter, latency 4 / 8-bit counter)
// share one stimulus stream; expected pixels are queued at drive time and popped per p_tick.
module tb_vga_out_pipe;
  typedef logic [5:0] ent_t;  // {hsync, vsync, video_on, rgb[2:0]}

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_out_pipe_if #(.RGB_W(3), .FCNT_W(2)) ifa ();
  vga_out_pipe_if #(.RGB_W(3), .FCNT_W(8)) ifb ();

  assign ifb.p_tick      = ifa.p_tick;
  assign ifb.video_on_in = ifa.video_on_in;
  assign ifb.hsync_in    = ifa.hsync_in;
  assign ifb.vsync_in    = ifa.vsync_in;
  assign ifb.pixel_x     = ifa.pixel_x;
  assign ifb.pixel_y     = ifa.pixel_y;
  assign ifb.graph_rgb   = ifa.graph_rgb;
  assign ifb.bg_rgb      = ifa.bg_rgb;
  assign ifb.mode_req    = ifa.mode_req;
  assign ifb.mode_load   = ifa.mode_load;

  vga_out_pipe #(.RGB_W(3), .PIXEL_LAT(2), .FCNT_W(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  vga_out_pipe #(.RGB_W(3), .PIXEL_LAT(4), .FCNT_W(8)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  int checks = 0;
  int errors = 0;

  ent_t qa[$];
  ent_t qb[$];
  ent_t last_a;
  ent_t last_b;
  logic [1:0] m_mode;
  logic [1:0] m_pend;
  logic       m_pend_v;
  int         m_fcnt;

  function automatic logic [2:0] exp_colour(input logic [1:0] mode, input logic von,
                                            input logic [9:0] x, input logic [2:0] g,
                                            input logic [2:0] bg);
    if (!von) return 3'b000;
    case (mode)
      2'd0:    return g;
      2'd1:    return x[8:6];
      2'd2:    return bg;
      default: return 3'b000;
    endcase
  endfunction

  // Compares both DUTs against the scoreboard heads and the mode/frame model.
  task automatic sample(input string tag);
    ent_t oa;
    ent_t ob;
    oa = {ifa.hsync, ifa.vsync, ifa.video_on, ifa.rgb};
    ob = {ifb.hsync, ifb.vsync, ifb.video_on, ifb.rgb};
    checks++;
    if (oa !== last_a) begin
      errors++;
      $display("FAIL %s sb_lat2 got %b want %b at %0t", tag, oa, last_a, $time);
    end
    checks++;
    if (ob !== last_b) begin
      errors++;
      $display("FAIL %s sb_lat4 got %b want %b at %0t", tag, ob, last_b, $time);
    end
    checks++;
    if (ifa.mode_active !== m_mode || ifb.mode_active !== m_mode) begin
      errors++;
      $display("FAIL %s mode_active got %0d/%0d want %0d", tag, ifa.mode_active,
               ifb.mode_active, m_mode);
    end
    checks++;
    if (ifa.mode_pending !== m_pend_v || ifb.mode_pending !== m_pend_v) begin
      errors++;
      $display("FAIL %s mode_pending got %b/%b want %b", tag, ifa.mode_pending,
               ifb.mode_pending, m_pend_v);
    end
    checks++;
    if (ifa.frame_cnt !== 2'(m_fcnt) || ifb.frame_cnt !== 8'(m_fcnt)) begin
      errors++;
      $display("FAIL %s frame_cnt got %0d/%0d want %0d", tag, ifa.frame_cnt, ifb.frame_cnt,
               m_fcnt);
    end
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic von,
                     input logic hs, input logic vs, input logic load, input logic [1:0] req,
                     input int gap);
    ent_t e;
    @(negedge clk);
    ifa.pixel_x     = x;
    ifa.pixel_y     = y;
    ifa.video_on_in = von;
    ifa.hsync_in    = hs;
    ifa.vsync_in    = vs;
    ifa.mode_load   = load;
    ifa.mode_req    = req;
    ifa.p_tick      = 1'b1;
    e = {hs, vs, von, exp_colour(m_mode, von, x, ifa.graph_rgb, ifa.bg_rgb)};
    qa.push_back(e);
    qb.push_back(e);
    if (x == 10'd0 && y == 10'd0) begin
      m_fcnt++;
      if (m_pend_v) begin
        m_mode   = m_pend;
        m_pend_v = 1'b0;
      end
    end
    if (load) begin
      m_pend   = req;
      m_pend_v = 1'b1;
    end
    @(posedge clk);
    #1;
    ifa.p_tick    = 1'b0;
    ifa.mode_load = 1'b0;
    last_a = qa.pop_front();
    last_b = qb.pop_front();
    sample("tick");
    for (int i = 0; i < gap; i++) begin
      @(posedge clk);
      #1;
      sample("hold");
    end
  endtask

  task automatic do_load(input logic [1:0] req);
    @(negedge clk);
    ifa.p_tick    = 1'b0;
    ifa.mode_load = 1'b1;
    ifa.mode_req  = req;
    m_pend   = req;
    m_pend_v = 1'b1;
    @(posedge clk);
    #1;
    ifa.mode_load = 1'b0;
    sample("load");
  endtask

  // Reset is asserted together with p_tick and mode_load to show it dominates both.
  task automatic do_reset();
    @(negedge clk);
    rst             = 1'b1;
    ifa.p_tick      = 1'b1;
    ifa.mode_load   = 1'b1;
    ifa.mode_req    = 2'd2;
    ifa.hsync_in    = 1'b1;
    ifa.vsync_in    = 1'b1;
    ifa.video_on_in = 1'b1;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    ifa.p_tick    = 1'b0;
    ifa.mode_load = 1'b0;
    m_mode   = 2'd0;
    m_pend   = 2'd0;
    m_pend_v = 1'b0;
    m_fcnt   = 0;
    qa.delete();
    qb.delete();
    qa.push_back('0);
    for (int i = 0; i < 3; i++) qb.push_back('0);
    last_a = '0;
    last_b = '0;
  endtask

  task automatic check_cleared(input string tag);
    checks++;
    if ({ifa.hsync, ifa.vsync, ifa.video_on, ifa.rgb} !== 6'b0 ||
        {ifb.hsync, ifb.vsync, ifb.video_on, ifb.rgb} !== 6'b0) begin
      errors++;
      $display("FAIL %s pipe got %b/%b want 000000", tag,
               {ifa.hsync, ifa.vsync, ifa.video_on, ifa.rgb},
               {ifb.hsync, ifb.vsync, ifb.video_on, ifb.rgb});
    end
    checks++;
    if (ifa.mode_active !== 2'd0 || ifa.mode_pending !== 1'b0 || ifa.frame_cnt !== 2'd0 ||
        ifb.mode_active !== 2'd0 || ifb.mode_pending !== 1'b0 || ifb.frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL %s ctrl got %0d %b %0d want 0 0 0", tag, ifa.mode_active,
               ifa.mode_pending, ifa.frame_cnt);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_cleared("reset");
  endtask

  task automatic test_latency();
    ifa.graph_rgb = 3'b101;
    for (int x = 10; x < 20; x++) begin
      pix(10'(x), 10'd5, 1'b1, (x != 13), 1'b1, 1'b0, 2'd0, 0);
      if (x == 14) begin
        checks++;
        if (ifa.hsync !== 1'b0 || ifa.rgb !== 3'b101) begin
          errors++;
          $display("FAIL latency hs/rgb got %b/%b want 0/101", ifa.hsync, ifa.rgb);
        end
      end
    end
  endtask

  task automatic test_blank();
    ifa.graph_rgb = 3'b111;
    for (int x = 636; x < 648; x++) begin
      pix(10'(x), 10'd10, (x < 640), 1'b1, 1'b1, 1'b0, 2'd0, 3);
      if (x == 642 || x == 643) begin
        checks++;
        if (ifb.video_on !== (x == 642) || ifb.rgb !== ((x == 642) ? 3'b111 : 3'b000)) begin
          errors++;
          $display("FAIL blank x=%0d von/rgb got %b/%b", x, ifb.video_on, ifb.rgb);
        end
      end
    end
  endtask

  task automatic test_bars();
    ifa.graph_rgb = 3'b110;
    for (int x = 0; x < 6; x++) begin
      pix(10'(x), 10'd100, 1'b1, 1'b1, 1'b1, (x == 1), 2'd1, 0);
    end
    checks++;
    if (ifa.mode_active !== 2'd0 || ifa.mode_pending !== 1'b1) begin
      errors++;
      $display("FAIL bars_wait got %0d/%b want 0/1", ifa.mode_active, ifa.mode_pending);
    end
    pix(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 0);
    for (int x = 0; x <= 512; x += 64) begin
      pix(10'(x), 10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 0);
      if (x == 128 || x == 512) begin
        checks++;
        if (ifa.rgb !== ((x == 128) ? 3'b001 : 3'b111)) begin
          errors++;
          $display("FAIL bars x=%0d rgb got %b", x - 64, ifa.rgb);
        end
      end
    end
  endtask

  task automatic test_last_wins();
    ifa.bg_rgb    = 3'b010;
    ifa.graph_rgb = 3'b111;
    do_load(2'd2);
    checks++;
    if (ifa.mode_pending !== 1'b1) begin
      errors++;
      $display("FAIL load_no_tick pending got %b want 1", ifa.mode_pending);
    end
    for (int x = 0; x < 8; x++) begin
      pix(10'(x), 10'd50, 1'b1, 1'b1, 1'b1, (x == 5), 2'd3, 0);
    end
    pix(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 0);
    checks++;
    if (ifa.mode_active !== 2'd3) begin
      errors++;
      $display("FAIL last_wins mode got %0d want 3", ifa.mode_active);
    end
    for (int i = 0; i < 24; i++) begin
      pix(10'(1 + i * 20), 10'(i / 8), 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 0);
      if (i >= 4) begin
        checks++;
        if (ifa.rgb !== 3'b000 || ifb.rgb !== 3'b000) begin
          errors++;
          $display("FAIL last_wins rgb got %b/%b want 000", ifa.rgb, ifb.rgb);
        end
      end
    end
  endtask

  task automatic test_frames();
    logic [1:0] seq [5];
    seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    ifa.graph_rgb = 3'b011;
    for (int f = 0; f < 5; f++) begin
      if (f == 3) do_load(2'd1);
      pix(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, (f == 3), 2'd2, 1);
      checks++;
      if (ifa.frame_cnt !== seq[f]) begin
        errors++;
        $display("FAIL frame_seq f=%0d got %0d want %0d", f, ifa.frame_cnt, seq[f]);
      end
      if (f >= 3) begin
        checks++;
        if (ifa.mode_active !== ((f == 3) ? 2'd1 : 2'd2) || ifa.mode_pending !== (f == 3)) begin
          errors++;
          $display("FAIL coincident f=%0d got %0d/%b", f, ifa.mode_active, ifa.mode_pending);
        end
      end
      for (int x = 1; x < 4; x++) pix(10'(x * 100), 10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 0);
    end
  endtask

  task automatic test_reset_mid();
    do_load(2'd1);
    pix(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 0);
    for (int x = 60; x < 70; x++) pix(10'(x), 10'd3, 1'b1, (x != 65), 1'b1, 1'b0, 2'd0, 0);
    do_load(2'd3);
    do_reset();
    check_cleared("reset_mid");
    for (int x = 0; x < 6; x++) pix(10'(x * 64), 10'd4, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1);
  endtask

  initial begin
    ifa.p_tick      = 1'b0;
    ifa.video_on_in = 1'b0;
    ifa.hsync_in    = 1'b1;
    ifa.vsync_in    = 1'b1;
    ifa.pixel_x     = 10'd5;
    ifa.pixel_y     = 10'd5;
    ifa.graph_rgb   = 3'b000;
    ifa.bg_rgb      = 3'b000;
    ifa.mode_req    = 2'd0;
    ifa.mode_load   = 1'b0;
    test_reset();
    test_latency();
    test_blank();
    test_bars();
    test_last_wins();
    test_frames();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
